// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_ctrl
//  Purpose  : Raster-stream sequencer for the convolution line-buffer window;
//             gates shifts, tracks position and flags complete kernel windows.
//  Revision : 1.0
// ============================================================================
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int KERNEL_WIDTH = 5,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             shift_en,
    output logic             window_valid,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] C_COL_LAST = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ROW_LAST = CNT_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] C_K_OFF    = CNT_W'(KERNEL_WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_out_row;
    logic [CNT_W-1:0] r_out_col;
    logic             r_window_valid;
    logic             r_busy;
    logic             r_frame_done;

    logic w_accept;
    logic w_col_last;
    logic w_last_pixel;
    logic w_in_window;

    assign in_ready     = (r_state == S_STREAM) && out_ready;
    assign w_accept     = in_valid && in_ready;
    assign shift_en     = w_accept;
    assign w_col_last   = (r_col == C_COL_LAST);
    assign w_last_pixel = w_col_last && (r_row == C_ROW_LAST);
    // Windows that would straddle a row wrap are excluded by the column test.
    assign w_in_window  = (r_row >= C_K_OFF) && (r_col >= C_K_OFF);

    assign window_valid = r_window_valid;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_STREAM;
            S_STREAM: if (w_accept && w_last_pixel) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != S_IDLE);
            r_frame_done <= w_accept && w_last_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // A presented window is held under backpressure until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window_valid <= 1'b0;
            r_out_row      <= '0;
            r_out_col      <= '0;
        end else if (w_accept) begin
            r_window_valid <= w_in_window;
            if (w_in_window) begin
                r_out_row <= r_row - C_K_OFF;
                r_out_col <= r_col - C_K_OFF;
            end
        end else if (out_ready) begin
            r_window_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_ctrl
//  Purpose  : Directed self-checking bench for conv_window_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_conv_window_ctrl;

    localparam int OW = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       shift_en;
    logic       window_valid;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       busy;
    logic       frame_done;

    int n_pass  = 0;
    int n_total = 0;

    conv_window_ctrl #(
        .IMAGE_WIDTH (28),
        .IMAGE_HEIGHT(28),
        .KERNEL_WIDTH(5),
        .CNT_W       (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .shift_en    (shift_en),
        .window_valid(window_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Observation of the stream: counts and raster-order window expectations.
    logic mon_clr = 1'b0;
    int   mon_shifts, mon_wins, mon_first, mon_coord_err, mon_fd, mon_fd_err;
    int   mon_bad_shift, mon_busy_err;
    logic last_shift = 1'b0;
    logic prev_fd = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_shifts = 0; mon_wins = 0; mon_first = -1; mon_coord_err = 0;
            mon_fd = 0; mon_fd_err = 0; mon_bad_shift = 0; mon_busy_err = 0;
        end else begin
            if (prev_fd && busy) mon_busy_err++;
            if (window_valid && last_shift) begin
                if (mon_wins == 0) mon_first = mon_shifts;
                if (out_row !== 5'(mon_wins / OW) || out_col !== 5'(mon_wins % OW))
                    mon_coord_err++;
                mon_wins++;
            end
            if (frame_done) begin
                mon_fd++;
                if (!window_valid || out_row !== 5'd23 || out_col !== 5'd23 || !busy)
                    mon_fd_err++;
            end
            if (shift_en && !in_valid) mon_bad_shift++;
            if (shift_en) mon_shifts++;
        end
        last_shift = shift_en;
        prev_fd    = frame_done;
    end

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    // Start a frame and stream it; gap is the percentage of idle in_valid cycles.
    task automatic run_frame(input int gap, input bit poke_start);
        bit seen = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            in_valid = ($urandom_range(0, 99) >= gap);
            start    = poke_start && (i == 400);
            @(posedge clk); #1;
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (poke_start) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (!seen) $display("FAIL frame_timeout: frame_done seen=%0d required=1", seen);
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready: got %0b want 0", in_ready); else n_pass++;
        n_total++; if (shift_en !== 1'b0) $display("FAIL idle_shift_en: got %0b want 0", shift_en); else n_pass++;
        n_total++; if (window_valid !== 1'b0) $display("FAIL idle_window_valid: got %0b want 0", window_valid); else n_pass++;
        n_total++; if (out_row !== 5'd0 || out_col !== 5'd0) $display("FAIL idle_coords: got %0d,%0d want 0,0", out_row, out_col); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL idle_frame_done: got %0b want 0", frame_done); else n_pass++;
        n_total++; if (mon_shifts !== 0) $display("FAIL idle_shift_count: got %0d want 0", mon_shifts); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        clear_mon();
        run_frame(0, 1'b0);
        n_total++; if (mon_shifts !== 784) $display("FAIL full_shifts: got %0d want 784", mon_shifts); else n_pass++;
        n_total++; if (mon_wins !== 576) $display("FAIL full_windows: got %0d want 576", mon_wins); else n_pass++;
        n_total++; if (mon_first !== 117) $display("FAIL full_first_window_accept: got %0d want 117", mon_first); else n_pass++;
        n_total++; if (mon_coord_err !== 0) $display("FAIL full_coords: got %0d errors want 0", mon_coord_err); else n_pass++;
        n_total++; if (mon_fd !== 1) $display("FAIL full_frame_done_count: got %0d want 1", mon_fd); else n_pass++;
        n_total++; if (mon_fd_err !== 0) $display("FAIL full_frame_done_window: got %0d errors want 0", mon_fd_err); else n_pass++;
        n_total++; if (mon_busy_err !== 0) $display("FAIL full_busy_drop: got %0d errors want 0", mon_busy_err); else n_pass++;
    endtask

    task automatic test_gaps();
        clear_mon();
        run_frame(30, 1'b0);
        n_total++; if (mon_shifts !== 784) $display("FAIL gap_shifts: got %0d want 784", mon_shifts); else n_pass++;
        n_total++; if (mon_wins !== 576) $display("FAIL gap_windows: got %0d want 576", mon_wins); else n_pass++;
        n_total++; if (mon_coord_err !== 0) $display("FAIL gap_coords: got %0d errors want 0", mon_coord_err); else n_pass++;
        n_total++; if (mon_bad_shift !== 0) $display("FAIL gap_shift_without_valid: got %0d want 0", mon_bad_shift); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        bit hold_ok = 1'b1;
        bit seen = 1'b0;
        clear_mon();
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (window_valid && out_row == 5'd3 && out_col == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        n_total++; if (!found) $display("FAIL bp_reach_3_7: found=%0d want 1", found); else n_pass++;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || shift_en !== 1'b0 || window_valid !== 1'b1 ||
                out_row !== 5'd3 || out_col !== 5'd7) begin
                hold_ok = 1'b0;
                $display("FAIL bp_hold cycle %0d: rdy=%0b sh=%0b wv=%0b at %0d,%0d want 0,0,1 at 3,7",
                         i, in_ready, shift_en, window_valid, out_row, out_col);
            end
            @(posedge clk); #1;
        end
        n_total++; if (hold_ok) n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (window_valid !== 1'b1 || out_row !== 5'd3 || out_col !== 5'd8)
            $display("FAIL bp_resume: wv=%0b at %0d,%0d want 1 at 3,8", window_valid, out_row, out_col);
        else n_pass++;
        for (int i = 0; i < 2000; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (!seen) $display("FAIL bp_frame_done: seen=%0d want 1", seen); else n_pass++;
        n_total++; if (mon_wins !== 576) $display("FAIL bp_windows: got %0d want 576", mon_wins); else n_pass++;
        n_total++; if (mon_coord_err !== 0) $display("FAIL bp_coords: got %0d errors want 0", mon_coord_err); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && mon_shifts < 300; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0 || shift_en !== 1'b0) $display("FAIL rst_ready_shift: got %0b,%0b want 0,0", in_ready, shift_en); else n_pass++;
        n_total++; if (window_valid !== 1'b0) $display("FAIL rst_window_valid: got %0b want 0", window_valid); else n_pass++;
        n_total++; if (out_row !== 5'd0 || out_col !== 5'd0) $display("FAIL rst_coords: got %0d,%0d want 0,0", out_row, out_col); else n_pass++;
        n_total++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL rst_busy_done: got %0b,%0b want 0,0", busy, frame_done); else n_pass++;
        in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        clear_mon();
        run_frame(0, 1'b0);
        n_total++; if (mon_wins !== 576) $display("FAIL rst_windows: got %0d want 576", mon_wins); else n_pass++;
        n_total++; if (mon_coord_err !== 0) $display("FAIL rst_coords_after: got %0d errors want 0", mon_coord_err); else n_pass++;
        n_total++; if (mon_fd !== 1) $display("FAIL rst_frame_done_count: got %0d want 1", mon_fd); else n_pass++;
    endtask

    task automatic test_start_ignored();
        clear_mon();
        run_frame(0, 1'b1);
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (mon_fd !== 1) $display("FAIL st_frame_done_count: got %0d want 1", mon_fd); else n_pass++;
        n_total++; if (mon_wins !== 576) $display("FAIL st_windows: got %0d want 576", mon_wins); else n_pass++;
        n_total++; if (mon_coord_err !== 0) $display("FAIL st_coords: got %0d errors want 0", mon_coord_err); else n_pass++;
        n_total++; if (busy !== 1'b0 || mon_shifts !== 784) $display("FAIL st_idle_after: busy=%0b shifts=%0d want 0,784", busy, mon_shifts); else n_pass++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_backpressure();
        test_reset_midframe();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
